// File: rtl/data_mem_access_unit.sv
// data_mem_access_unit: MEM-stage load/store unit driving a req/ack word bus.
// Optional ack watchdog is compiled in when DMEM_TIMEOUT_EN is defined.
module data_mem_access_unit #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        READ_WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [31:0]       WRITE_DATA,
  output logic [31:0]       READ_DATA,
  output logic              BUSYWAIT,
  output logic              MISALIGNED,
  output logic              BUS_ERROR,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_WDATA,
  input  logic [31:0]       MEM_RDATA,
  input  logic              MEM_ACK
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end

  logic [1:0]        state_q, state_d;
  logic [31:0]       rdata_q;
  logic              mis_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic              ld_byte_q, ld_half_q, ld_uns_q;
  logic [1:0]        off_q;

  logic is_byte, is_half, is_word, is_store, is_uns;
  logic aligned, start, mis, expire;
  logic [3:0]  be_s;
  logic [31:0] wd_s;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_fmt;

  always_comb begin
    is_byte  = 1'b0;
    is_half  = 1'b0;
    is_word  = 1'b0;
    is_store = 1'b0;
    is_uns   = 1'b0;
    case (READ_WRITE[2:0])
      3'b000: is_byte = 1'b1;
      3'b001: is_half = 1'b1;
      3'b010: is_word = 1'b1;
      3'b011: begin is_byte = 1'b1; is_store = 1'b1; end
      3'b100: begin is_byte = 1'b1; is_uns = 1'b1; end
      3'b101: begin is_half = 1'b1; is_uns = 1'b1; end
      3'b110: begin is_half = 1'b1; is_store = 1'b1; end
      3'b111: begin is_word = 1'b1; is_store = 1'b1; end
      default: ;
    endcase
  end

  assign aligned = is_byte
                 | (is_half & ~ADDRESS[0])
                 | (is_word & (ADDRESS[1:0] == 2'b00));
  assign start   = (state_q == S_IDLE) & READ_WRITE[3] & aligned;
  assign mis     = (state_q == S_IDLE) & READ_WRITE[3] & ~aligned;
  assign BUSYWAIT = start | (state_q == S_ACCESS);

  // Stores replicate the datum so any enabled lane carries it.
  always_comb begin
    be_s = 4'b1111;
    wd_s = WRITE_DATA;
    if (is_byte) begin
      be_s = 4'b0001 << ADDRESS[1:0];
      wd_s = {4{WRITE_DATA[7:0]}};
    end else if (is_half) begin
      be_s = ADDRESS[1] ? 4'b1100 : 4'b0011;
      wd_s = {2{WRITE_DATA[15:0]}};
    end
  end

  always_comb begin
    lb = MEM_RDATA[{off_q, 3'b000} +: 8];
    lh = off_q[1] ? MEM_RDATA[31:16] : MEM_RDATA[15:0];
    ld_fmt = MEM_RDATA;
    if (ld_byte_q)
      ld_fmt = ld_uns_q ? {24'd0, lb} : {{24{lb[7]}}, lb};
    else if (ld_half_q)
      ld_fmt = ld_uns_q ? {16'd0, lh} : {{16{lh[15]}}, lh};
  end

`ifdef DMEM_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CW     = (CW_RAW < 8) ? 8 : CW_RAW;

  logic [CW-1:0] cnt_q;
  logic          berr_q;

  // Ack wins when it lands on the same cycle the limit is reached.
  assign expire = (state_q == S_ACCESS) & ~MEM_ACK
                & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else begin
      berr_q <= expire;
      if (start)
        cnt_q <= '0;
      else if ((state_q == S_ACCESS) && !MEM_ACK)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign BUS_ERROR = berr_q;
`else
  assign expire    = 1'b0;
  assign BUS_ERROR = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_ACCESS;
      S_ACCESS: if (MEM_ACK || expire) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      ld_byte_q <= 1'b0;
      ld_half_q <= 1'b0;
      ld_uns_q  <= 1'b0;
      off_q     <= '0;
    end else begin
      state_q <= state_d;
      mis_q   <= mis;
      if (start) begin
        req_q     <= 1'b1;
        we_q      <= is_store;
        addr_q    <= {ADDRESS[ADDR_W-1:2], 2'b00};
        be_q      <= be_s;
        wdata_q   <= wd_s;
        ld_byte_q <= is_byte;
        ld_half_q <= is_half;
        ld_uns_q  <= is_uns;
        off_q     <= ADDRESS[1:0];
      end
      if (state_q == S_ACCESS) begin
        if (MEM_ACK) begin
          req_q <= 1'b0;
          if (!we_q) rdata_q <= ld_fmt;
        end else if (expire) begin
          req_q <= 1'b0;
        end
      end
    end
  end

  assign READ_DATA  = rdata_q;
  assign MISALIGNED = mis_q;
  assign MEM_REQ    = req_q;
  assign MEM_WE     = we_q;
  assign MEM_ADDR   = addr_q;
  assign MEM_BE     = be_q;
  assign MEM_WDATA  = wdata_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb_data_mem_access_unit: randomized load/store traffic against a
// transaction-level model of the access unit and a 16-word bus memory.
module tb_data_mem_access_unit;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  READ_WRITE = 4'd0;
  logic [31:0] ADDRESS = '0;
  logic [31:0] WRITE_DATA = '0;
  logic [31:0] READ_DATA;
  logic        BUSYWAIT, MISALIGNED, BUS_ERROR;
  logic        MEM_REQ, MEM_WE;
  logic [31:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;

  localparam int TO = 4;

  always #5 CLK = ~CLK;

  data_mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE),
    .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
    .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT),
    .MISALIGNED(MISALIGNED), .BUS_ERROR(BUS_ERROR),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        chk_on = 1'b0;
  logic        e_busy = 0, e_req = 0, e_we = 0, e_mis = 0, e_berr = 0;
  logic        chk_bus = 0, chk_wd = 0;
  logic [31:0] e_addr = 0, e_wdata = 0, e_rd = 0;
  logic [3:0]  e_be = 0;
  logic [31:0] mem [16];

  int busy_cnt = 0, req_cnt = 0, mis_cnt = 0, berr_cnt = 0, wr_seen = 0;
  logic [31:0] last_addr = 0, last_wdata = 0;
  logic [3:0]  last_be = 0;
  logic        last_we = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("BUSYWAIT", 32'(BUSYWAIT), 32'(e_busy));
      chk("MEM_REQ", 32'(MEM_REQ), 32'(e_req));
      chk("MISALIGNED", 32'(MISALIGNED), 32'(e_mis));
      chk("BUS_ERROR", 32'(BUS_ERROR), 32'(e_berr));
      chk("READ_DATA", READ_DATA, e_rd);
      if (chk_bus) begin
        chk("MEM_ADDR", MEM_ADDR, e_addr);
        chk("MEM_BE", 32'(MEM_BE), 32'(e_be));
        chk("MEM_WE", 32'(MEM_WE), 32'(e_we));
        if (chk_wd) chk("MEM_WDATA", MEM_WDATA, e_wdata);
      end
    end
    if (BUSYWAIT) busy_cnt++;
    if (MISALIGNED) mis_cnt++;
    if (BUS_ERROR) berr_cnt++;
    if (MEM_REQ) begin
      req_cnt++;
      last_addr  = MEM_ADDR;
      last_be    = MEM_BE;
      last_we    = MEM_WE;
      last_wdata = MEM_WDATA;
    end
  end

  always @(posedge CLK)
    if (MEM_REQ && MEM_ACK && MEM_WE) wr_seen++;

  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'b000, 3'b100, 3'b011: return 1;
      3'b001, 3'b101, 3'b110: return 2;
      default:                return 4;
    endcase
  endfunction

  function automatic bit is_st(input logic [2:0] c);
    return (c == 3'b011) || (c == 3'b110) || (c == 3'b111);
  endfunction

  function automatic logic [3:0] be_of(input logic [2:0] c,
                                       input logic [1:0] off);
    int sz;
    logic [3:0] m;
    sz = size_of(c);
    m = (sz == 1) ? 4'b0001 : (sz == 2) ? 4'b0011 : 4'b1111;
    return m << off;
  endfunction

  function automatic logic [31:0] wd_of(input logic [2:0] c,
                                        input logic [31:0] d);
    int sz;
    sz = size_of(c);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  function automatic logic [31:0] ld_of(input logic [2:0] c,
                                        input logic [1:0] off,
                                        input logic [31:0] w);
    int sz;
    logic [31:0] v, m;
    sz = size_of(c);
    v = w >> (8 * off);
    m = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
    v = v & m;
    if ((c == 3'b000 || c == 3'b001) && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_op(input logic [3:0] rw, input logic [31:0] addr,
                       input logic [31:0] wd, input int waits,
                       input bit to);
    logic [2:0] c;
    logic [3:0] be;
    bit ack;
    int idx;
    c = rw[2:0];
    idx = int'(addr[5:2]);
    READ_WRITE = rw;
    ADDRESS = addr;
    WRITE_DATA = wd;
    MEM_ACK = 1'b0;
    MEM_RDATA = $urandom;
    e_mis = 0; e_berr = 0; e_req = 0; chk_bus = 0;
    if (!rw[3]) begin
      e_busy = 0;
      step();
      return;
    end
    if ((addr % size_of(c)) != 0) begin
      e_busy = 0;
      step();
      READ_WRITE = 4'($urandom_range(0, 7));
      e_mis = 1;
      step();
      e_mis = 0;
      READ_WRITE = 4'd0;
      return;
    end
    e_busy = 1;
    step();
    be = be_of(c, addr[1:0]);
    e_req = 1; chk_bus = 1; chk_wd = is_st(c);
    e_addr = addr & ~32'd3; e_be = be; e_we = is_st(c);
    e_wdata = wd_of(c, wd);
    ack = 0;
    for (int k = 0; k < 64; k++) begin
      ack = !to && (k == waits);
      MEM_ACK = ack;
      MEM_RDATA = ack ? mem[idx] : $urandom;
      if (!ack && (k % 2 == 1)) READ_WRITE = rw;
      step();
      if (ack || (to && k == TO - 1)) break;
    end
    MEM_ACK = 1'b0;
    MEM_RDATA = $urandom;
    READ_WRITE = 4'($urandom);
    e_busy = 0; e_req = 0; chk_bus = 0;
    if (ack && !is_st(c)) e_rd = ld_of(c, addr[1:0], mem[idx]);
    if (ack && is_st(c))
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] = e_wdata[8*i +: 8];
    if (to) e_berr = 1;
    step();
    e_berr = 0;
    READ_WRITE = 4'd0;
  endtask

  initial begin
    int w0;
    logic [3:0] rw;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;

    step();
    chk_on = 1'b1;
    chk_bus = 1; chk_wd = 1;
    step();
    RESET = 1'b0;
    chk_bus = 0;

    mem[0] = 32'hDEADBEEF;
    busy_cnt = 0;
    do_op(4'b1010, 32'h100, 32'h0, 0, 0);
    chk("lw_rdata", READ_DATA, 32'hDEADBEEF);
    chk("lw_addr", last_addr, 32'h100);
    chk("lw_be", 32'(last_be), 32'hF);
    chk("lw_we", 32'(last_we), 32'h0);
    chk("lw_busy_cycles", busy_cnt, 2);

    mem[0] = 32'h80112233;
    do_op(4'b1000, 32'h203, 32'h0, 1, 0);
    chk("lb_rdata", READ_DATA, 32'hFFFFFF80);
    chk("lb_addr", last_addr, 32'h200);
    do_op(4'b1100, 32'h203, 32'h0, 0, 0);
    chk("lbu_rdata", READ_DATA, 32'h00000080);

    busy_cnt = 0;
    do_op(4'b1110, 32'h302, 32'h0000ABCD, 3, 0);
    chk("sh_wdata", last_wdata, 32'hABCDABCD);
    chk("sh_be", 32'(last_be), 32'hC);
    chk("sh_we", 32'(last_we), 32'h1);
    chk("sh_busy_cycles", busy_cnt, 5);
    chk("sh_rdata_kept", READ_DATA, 32'h00000080);

    busy_cnt = 0; req_cnt = 0; mis_cnt = 0;
    do_op(4'b1010, 32'h102, 32'h0, 0, 0);
    do_op(4'b1110, 32'h101, 32'h0, 0, 0);
    step();
    chk("mis_pulses", mis_cnt, 2);
    chk("mis_req_cycles", req_cnt, 0);
    chk("mis_busy_cycles", busy_cnt, 0);

    READ_WRITE = 4'b1111; ADDRESS = 32'h40; WRITE_DATA = $urandom;
    MEM_ACK = 0; e_busy = 1; e_req = 0; chk_bus = 0;
    step();
    e_req = 1; chk_bus = 1; chk_wd = 1; e_we = 1; e_be = 4'hF;
    e_addr = 32'h40; e_wdata = WRITE_DATA;
    step();
    RESET = 1'b1;
    step();
    w0 = wr_seen;
    RESET = 1'b0; MEM_ACK = 1'b1; READ_WRITE = 4'd0;
    e_busy = 0; e_req = 0; e_rd = 0; e_mis = 0;
    e_addr = 0; e_be = 0; e_we = 0; e_wdata = 0;
    chk("rst_req_after_edge", 32'(MEM_REQ), 32'h0);
    step();
    MEM_ACK = 1'b0;
    step();
    chk("rst_no_write", wr_seen, w0);
    chk_bus = 0;

`ifdef DMEM_TIMEOUT_EN
    berr_cnt = 0;
    mem[1] = 32'h12345678;
    do_op(4'b1010, 32'h104, 32'h0, 0, 0);
    do_op(4'b1010, 32'h108, 32'h0, 0, 1);
    chk("to_berr_pulses", berr_cnt, 1);
    chk("to_rdata_kept", READ_DATA, 32'h12345678);
`endif

    for (int n = 0; n < 120; n++) begin
      if ($urandom_range(0, 5) == 0) rw = 4'($urandom_range(0, 7));
      else rw = {1'b1, 3'($urandom)};
      do_op(rw, 32'h1000 | ($urandom & 32'h3F), $urandom,
            $urandom_range(0, 3), 0);
    end

    berr_cnt = 0;
    step();
    chk("no_stray_berr", berr_cnt, 0);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
